// File: rtl/ddram_arb_pkg.sv
// Shared types and constants for the DDR3 Avalon-MM port arbiter.
package ddram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } arb_state_e;

  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int BC_W   = 8;

  // A burst count of zero is treated as a single-beat burst.
  function automatic logic [BC_W-1:0] bc_norm(input logic [BC_W-1:0] bc);
    return (bc == '0) ? BC_W'(1) : bc;
  endfunction

endpackage

// File: rtl/ddram_arb_pick.sv
// Winner selection for the arbiter: lowest index wins, or a rotating search
// starting at ptr_i when DDRAM_ARB_RR_EN is defined.
module ddram_arb_pick
  import ddram_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NPORTS-1:0] req_i,
`ifdef DDRAM_ARB_RR_EN
  input  logic [IDX_W-1:0]  ptr_i,
`endif
  output logic              any_o,
  output logic [IDX_W-1:0]  win_o
);

`ifdef DDRAM_ARB_RR_EN
  logic [IDX_W:0] idx;

  // Scan from the farthest candidate back to ptr_i so the first hit after ptr_i is kept.
  always_comb begin
    any_o = |req_i;
    win_o = '0;
    idx   = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NPORTS)) idx = idx - (IDX_W+1)'(NPORTS);
      if (req_i[idx[IDX_W-1:0]]) win_o = idx[IDX_W-1:0];
    end
  end
`else
  always_comb begin
    any_o = |req_i;
    win_o = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (req_i[k]) win_o = IDX_W'(k);
    end
  end
`endif

endmodule

// File: rtl/ddram_arb.sv
// Whole-transaction arbiter sharing the DDRAM_* Avalon-MM port between NPORTS
// bursting masters. Define DDRAM_ARB_RR_EN for round-robin instead of fixed priority.
module ddram_arb
  import ddram_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int ADDR_W = 29
) (
  input  logic                     DDRAM_CLK,
  input  logic                     reset,

  input  logic [BC_W*NPORTS-1:0]   REQ_BURSTCNT,
  input  logic [ADDR_W*NPORTS-1:0] REQ_ADDR,
  input  logic [NPORTS-1:0]        REQ_RD,
  input  logic [NPORTS-1:0]        REQ_WE,
  input  logic [DATA_W*NPORTS-1:0] REQ_DIN,
  input  logic [BE_W*NPORTS-1:0]   REQ_BE,
  output logic [NPORTS-1:0]        REQ_BUSY,
  output logic [DATA_W-1:0]        REQ_DOUT,
  output logic [NPORTS-1:0]        REQ_DOUT_READY,

  input  logic                     DDRAM_BUSY,
  output logic [BC_W-1:0]          DDRAM_BURSTCNT,
  output logic [ADDR_W-1:0]        DDRAM_ADDR,
  output logic                     DDRAM_RD,
  output logic                     DDRAM_WE,
  output logic [DATA_W-1:0]        DDRAM_DIN,
  output logic [BE_W-1:0]          DDRAM_BE,
  input  logic [DATA_W-1:0]        DDRAM_DOUT,
  input  logic                     DDRAM_DOUT_READY
);

  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [BC_W-1:0]  cnt_q, cnt_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_win;

  logic             g_rd, g_we;
  logic [BC_W-1:0]  g_bc;

  assign g_rd = REQ_RD[gnt_q];
  assign g_we = REQ_WE[gnt_q];
  assign g_bc = bc_norm(REQ_BURSTCNT[int'(gnt_q)*BC_W +: BC_W]);

`ifdef DDRAM_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] w);
    logic [IDX_W:0] s;
    s = {1'b0, w} + (IDX_W+1)'(1);
    if (s >= (IDX_W+1)'(NPORTS)) s = '0;
    return s[IDX_W-1:0];
  endfunction

  ddram_arb_pick #(
    .NPORTS (NPORTS),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i  (REQ_RD | REQ_WE),
    .ptr_i  (ptr_q),
    .any_o  (pick_any),
    .win_o  (pick_win)
  );

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && pick_any) ptr_d = ptr_after(pick_win);
  end
`else
  ddram_arb_pick #(
    .NPORTS (NPORTS),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i  (REQ_RD | REQ_WE),
    .any_o  (pick_any),
    .win_o  (pick_win)
  );
`endif

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_win;
          state_d = OWN;
        end
      end
      OWN: begin
        // A simultaneous rd+we is a master protocol error; the read takes precedence.
        if (g_rd) begin
          if (!DDRAM_BUSY) begin
            cnt_d   = g_bc;
            state_d = RD;
          end
        end else if (g_we) begin
          if (!DDRAM_BUSY) begin
            if (g_bc == BC_W'(1)) begin
              state_d = IDLE;
            end else begin
              cnt_d   = g_bc - BC_W'(1);
              state_d = WR;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        if (g_we && !DDRAM_BUSY) begin
          cnt_d = cnt_q - BC_W'(1);
          if (cnt_q == BC_W'(1)) state_d = IDLE;
        end
      end
      RD: begin
        if (DDRAM_DOUT_READY) begin
          cnt_d = cnt_q - BC_W'(1);
          if (cnt_q == BC_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the owner sees the DDR waitrequest; read data is steered to it alone.
  always_comb begin
    DDRAM_RD       = 1'b0;
    DDRAM_WE       = 1'b0;
    REQ_BUSY       = '1;
    REQ_DOUT_READY = '0;
    case (state_q)
      OWN: begin
        DDRAM_RD        = g_rd;
        DDRAM_WE        = g_we & ~g_rd;
        REQ_BUSY[gnt_q] = DDRAM_BUSY;
      end
      WR: begin
        DDRAM_WE        = g_we;
        REQ_BUSY[gnt_q] = DDRAM_BUSY;
      end
      RD: begin
        REQ_DOUT_READY[gnt_q] = DDRAM_DOUT_READY;
      end
      default: ;
    endcase
  end

  assign DDRAM_BURSTCNT = g_bc;
  assign DDRAM_ADDR     = REQ_ADDR[int'(gnt_q)*ADDR_W +: ADDR_W];
  assign DDRAM_DIN      = REQ_DIN[int'(gnt_q)*DATA_W +: DATA_W];
  assign DDRAM_BE       = REQ_BE[int'(gnt_q)*BE_W +: BE_W];
  assign REQ_DOUT       = DDRAM_DOUT;

endmodule
